ahb_lite_cmd_master: RTL and testbench



---
 rtl/ahb_pkg.sv | 28 ++
 rtl/ahb_master_dphase_ctrl.sv | 110 +++++++++++
 rtl/ahb_lite_cmd_master.sv | 119 +++++++++++
 tb/tb_ahb_lite_cmd_master.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_pkg - AHB-Lite encodings and data-phase tracker state type        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package ahb_pkg;
  localparam logic [1:0] c_htrans_idle   = 2'b00;
  localparam logic [1:0] c_htrans_busy   = 2'b01;
  localparam logic [1:0] c_htrans_nonseq = 2'b10;
  localparam logic [1:0] c_htrans_seq    = 2'b11;

  localparam logic [2:0] c_hburst_single = 3'b000;
  localparam logic [2:0] c_hburst_incr   = 3'b001;

  localparam logic [2:0] c_hsize_byte    = 3'b000;
  localparam logic [2:0] c_hsize_half    = 3'b001;
  localparam logic [2:0] c_hsize_word    = 3'b010;

  localparam logic       c_hresp_okay    = 1'b0;
  localparam logic       c_hresp_error   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR2 = 2'd2
  } dphase_state_e;
endpackage
`default_nettype wire

// File: rtl/ahb_master_dphase_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_master_dphase_ctrl - data-phase tracker, ERROR cancellation and   |
// | response generation for ahb_lite_cmd_master.  Rev 1.0                 |
// +----------------------------------------------------------------------+
module ahb_master_dphase_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        hready,
  input  logic        hresp,
  input  logic        addr_active,
  input  logic        addr_write,
  input  logic [31:0] wdata_pend,
  input  logic [31:0] hrdata,
  output logic        cancel,
  output logic [31:0] hwdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  import ahb_pkg::*;

  dphase_state_e state_q, state_d;
  logic        dwrite_q, dwrite_d;
  logic        drop_q, drop_d;
  logic        drop_fire_q, drop_fire_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        handoff, complete;

  assign handoff  = addr_active & hready;
  assign complete = (state_q != ST_IDLE) & hready;
  assign cancel   = (state_q == ST_DATA) & (hresp == c_hresp_error) & ~hready;

  always_comb begin
    state_d     = state_q;
    dwrite_d    = dwrite_q;
    drop_d      = drop_q;
    drop_fire_d = 1'b0;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: if (handoff) state_d = ST_DATA;
      ST_DATA: begin
        if (cancel) begin
          state_d = ST_ERR2;
          drop_d  = addr_active;
        end else if (complete) begin
          state_d = handoff ? ST_DATA : ST_IDLE;
        end
      end
      ST_ERR2: if (hready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (complete) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = hresp;
      rsp_rdata_d = dwrite_q ? 32'h0 : hrdata;
      if (state_q == ST_ERR2) begin
        drop_fire_d = drop_q;
        drop_d      = 1'b0;
      end
    end

    // The cancelled command answers one cycle after the erroring transfer.
    if (drop_fire_q) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
    end

    if (handoff) begin
      dwrite_d = addr_write;
      if (addr_write) hwdata_d = wdata_pend;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dwrite_q    <= 1'b0;
      drop_q      <= 1'b0;
      drop_fire_q <= 1'b0;
      hwdata_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwrite_q    <= dwrite_d;
      drop_q      <= drop_d;
      drop_fire_q <= drop_fire_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign hwdata    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
endmodule
`default_nettype wire

// File: rtl/ahb_lite_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_lite_cmd_master - valid/ready command stream to AHB-Lite singles; |
// | optional INCR/SEQ via AHB_MASTER_INCR_BURST_EN.  Rev 1.0              |
// +----------------------------------------------------------------------+
module ahb_lite_cmd_master #(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [2:0]    cmd_size,
  input  logic [31:0]   cmd_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [2:0]    HBURST,
  output logic [31:0]   HWDATA,
  input  logic [31:0]   HRDATA,
  input  logic          HREADY,
  input  logic          HRESP
);
  import ahb_pkg::*;

  logic [1:0]    htrans_q, htrans_d;
  logic [AW-1:0] haddr_q, haddr_d;
  logic          hwrite_q, hwrite_d;
  logic [2:0]    hsize_q, hsize_d;
  logic [2:0]    hburst_q, hburst_d;
  logic [31:0]   wdata_pend_q, wdata_pend_d;
  logic          err1, accept, cancel, seq_ok;

  assign err1      = (HRESP == c_hresp_error) & ~HREADY;
  assign cmd_ready = HREADY & ~err1;
  assign accept    = cmd_valid & cmd_ready;

`ifdef AHB_MASTER_INCR_BURST_EN
  localparam logic [2:0] c_hburst = c_hburst_incr;
  logic [AW-1:0] addr_step;
  assign addr_step = {{(AW-1){1'b0}}, 1'b1} << hsize_q;
  // Continue the burst only from a live address phase within the same 1 KB page.
  assign seq_ok = htrans_q[1] & (cmd_write == hwrite_q) & (cmd_size == hsize_q) &
                  (cmd_addr == haddr_q + addr_step) & ((cmd_addr >> 10) == (haddr_q >> 10));
`else
  localparam logic [2:0] c_hburst = c_hburst_single;
  assign seq_ok = 1'b0;
`endif

  always_comb begin
    htrans_d     = htrans_q;
    haddr_d      = haddr_q;
    hwrite_d     = hwrite_q;
    hsize_d      = hsize_q;
    hburst_d     = hburst_q;
    wdata_pend_d = wdata_pend_q;
    if (cancel) begin
      htrans_d = c_htrans_idle;
    end else if (HREADY) begin
      hburst_d = c_hburst;
      if (accept) begin
        htrans_d     = seq_ok ? c_htrans_seq : c_htrans_nonseq;
        haddr_d      = cmd_addr;
        hwrite_d     = cmd_write;
        hsize_d      = cmd_size;
        wdata_pend_d = cmd_wdata;
      end else begin
        htrans_d = c_htrans_idle;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      htrans_q     <= c_htrans_idle;
      haddr_q      <= '0;
      hwrite_q     <= 1'b0;
      hsize_q      <= c_hsize_byte;
      hburst_q     <= c_hburst_single;
      wdata_pend_q <= 32'h0;
    end else begin
      htrans_q     <= htrans_d;
      haddr_q      <= haddr_d;
      hwrite_q     <= hwrite_d;
      hsize_q      <= hsize_d;
      hburst_q     <= hburst_d;
      wdata_pend_q <= wdata_pend_d;
    end
  end

  ahb_master_dphase_ctrl u_dphase (
    .clk         (HCLK),
    .rst         (HRESET),
    .hready      (HREADY),
    .hresp       (HRESP),
    .addr_active (htrans_q[1]),
    .addr_write  (hwrite_q),
    .wdata_pend  (wdata_pend_q),
    .hrdata      (HRDATA),
    .cancel      (cancel),
    .hwdata      (HWDATA),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err)
  );

  assign HTRANS = htrans_q;
  assign HADDR  = haddr_q;
  assign HWRITE = hwrite_q;
  assign HSIZE  = hsize_q;
  assign HBURST = hburst_q;
endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_cmd_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ahb_lite_cmd_master - directed self-checking bench                |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_ahb_lite_cmd_master;
  localparam int AW = 16;

`ifdef AHB_MASTER_INCR_BURST_EN
  localparam logic [2:0] c_exp_burst = 3'b001;
  localparam logic [1:0] c_exp_mid   = 2'b11;
`else
  localparam logic [2:0] c_exp_burst = 3'b000;
  localparam logic [1:0] c_exp_mid   = 2'b10;
`endif

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [2:0]    cmd_size;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid, rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE, HBURST;
  logic [31:0]   HWDATA, HRDATA;
  logic          HREADY, HRESP;

  int n_checks = 0;
  int n_errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_cmd_master #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic offer(input logic wr, input logic [AW-1:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_size  = 3'd2;
    cmd_wdata = d;
  endtask

  task automatic idle_cmd();
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_size  = 3'd0;
    cmd_wdata = 32'h0;
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_htrans"}, 32'(HTRANS), 32'h0);
    check_eq({tag, "_haddr"}, 32'(HADDR), 32'h0);
    check_eq({tag, "_hwrite"}, 32'(HWRITE), 32'h0);
    check_eq({tag, "_hsize"}, 32'(HSIZE), 32'h0);
    check_eq({tag, "_hburst"}, 32'(HBURST), 32'h0);
    check_eq({tag, "_hwdata"}, HWDATA, 32'h0);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check_eq({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
  endtask

  // Four reads with two wait states on the second data phase.
  bit          t2_cv   [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
  logic [15:0] t2_addr [9] = '{16'h0, 16'h4, 16'h8, 16'hC, 16'hC, 16'hC, 16'h0, 16'h0, 16'h0};
  bit          t2_rdy  [9] = '{1, 1, 1, 0, 0, 1, 1, 1, 1};
  logic [31:0] t2_hrd  [9] = '{32'h0, 32'h0, 32'h11110000, 32'hBADBAD00, 32'hBADBAD00,
                               32'h22221111, 32'h33332222, 32'h44443333, 32'h0};
  logic [1:0]  t2_tr   [9] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
  logic [15:0] t2_ha   [9] = '{16'h40, 16'h0, 16'h4, 16'h8, 16'h8, 16'h8, 16'hC, 16'hC, 16'hC};
  bit          t2_rv   [9] = '{0, 0, 0, 1, 0, 0, 1, 1, 1};
  logic [31:0] t2_rd   [9] = '{32'h0, 32'h0, 32'h0, 32'h11110000, 32'h0, 32'h0,
                               32'h22221111, 32'h33332222, 32'h44443333};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_cmd();
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'h0;
    repeat (2) tick();
    check_reset_outs("rst");
    HRESET = 1'b0;
    check_eq("rdy_after_rst", 32'(cmd_ready), 32'h1);

    // Single write, zero wait states
    offer(1'b1, 16'h0040, 32'hDEADBEEF);
    check_eq("t1_ready", 32'(cmd_ready), 32'h1);
    tick();
    idle_cmd();
    check_eq("t1_htrans", 32'(HTRANS), 32'h2);
    check_eq("t1_haddr", 32'(HADDR), 32'h40);
    check_eq("t1_hwrite", 32'(HWRITE), 32'h1);
    check_eq("t1_hsize", 32'(HSIZE), 32'h2);
    check_eq("t1_hburst", 32'(HBURST), 32'(c_exp_burst));
    check_eq("t1_rv_n1", 32'(rsp_valid), 32'h0);
    tick();
    check_eq("t1_htrans_idle", 32'(HTRANS), 32'h0);
    check_eq("t1_hwdata", HWDATA, 32'hDEADBEEF);
    check_eq("t1_rv_n2", 32'(rsp_valid), 32'h0);
    tick();
    check_eq("t1_rv_n3", 32'(rsp_valid), 32'h1);
    check_eq("t1_err", 32'(rsp_err), 32'h0);
    check_eq("t1_rdata", rsp_rdata, 32'h0);
    tick();
    check_eq("t1_rv_n4", 32'(rsp_valid), 32'h0);

    // Back-to-back reads with waits
    for (int i = 0; i < 9; i++) begin
      cmd_valid = t2_cv[i];
      cmd_write = 1'b0;
      cmd_addr  = t2_addr[i];
      cmd_size  = 3'd2;
      HREADY    = t2_rdy[i];
      HRDATA    = t2_hrd[i];
      #1;
      check_eq($sformatf("t2_ready_c%0d", i), 32'(cmd_ready), 32'(t2_rdy[i]));
      check_eq($sformatf("t2_htrans_c%0d", i), 32'(HTRANS), 32'(t2_tr[i]));
      check_eq($sformatf("t2_haddr_c%0d", i), 32'(HADDR), 32'(t2_ha[i]));
      check_eq($sformatf("t2_rv_c%0d", i), 32'(rsp_valid), 32'(t2_rv[i]));
      if (t2_rv[i]) begin
        check_eq($sformatf("t2_rdata_c%0d", i), rsp_rdata, t2_rd[i]);
        check_eq($sformatf("t2_err_c%0d", i), 32'(rsp_err), 32'h0);
      end
      tick();
    end
    idle_cmd();
    HREADY = 1'b1;
    HRDATA = 32'h0;
    check_eq("t2_rv_end", 32'(rsp_valid), 32'h0);

    // ERROR on read 0x100 while 0x104 sits in the address phase
    offer(1'b0, 16'h0100, 32'h0);
    tick();
    offer(1'b0, 16'h0104, 32'h0);
    tick();
    idle_cmd();
    HREADY = 1'b0;
    HRESP  = 1'b1;
    #1;
    check_eq("t3_ready_err1", 32'(cmd_ready), 32'h0);
    check_eq("t3_htrans_err1", 32'(HTRANS), 32'h2);
    check_eq("t3_haddr_err1", 32'(HADDR), 32'h104);
    tick();
    HREADY = 1'b1;
    check_eq("t3_htrans_err2", 32'(HTRANS), 32'h0);
    check_eq("t3_rv_err2", 32'(rsp_valid), 32'h0);
    tick();
    HRESP = 1'b0;
    check_eq("t3_rv_first", 32'(rsp_valid), 32'h1);
    check_eq("t3_err_first", 32'(rsp_err), 32'h1);
    tick();
    check_eq("t3_rv_drop", 32'(rsp_valid), 32'h1);
    check_eq("t3_err_drop", 32'(rsp_err), 32'h1);
    tick();
    check_eq("t3_rv_after", 32'(rsp_valid), 32'h0);
    check_eq("t3_htrans_after", 32'(HTRANS), 32'h0);

    // Asynchronous reset in a stalled write data phase
    offer(1'b1, 16'h0080, 32'h12345678);
    tick();
    idle_cmd();
    check_eq("t4_htrans", 32'(HTRANS), 32'h2);
    tick();
    HREADY = 1'b0;
    #1;
    check_eq("t4_hwdata", HWDATA, 32'h12345678);
    #2;
    HRESET = 1'b1;
    #1;
    check_reset_outs("t4_async");
    tick();
    tick();
    HREADY = 1'b1;
    HRESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t4_no_rsp_%0d", i), 32'(rsp_valid), 32'h0);
      tick();
    end
    offer(1'b0, 16'h0044, 32'h0);
    check_eq("t4_ready", 32'(cmd_ready), 32'h1);
    tick();
    idle_cmd();
    check_eq("t4_new_htrans", 32'(HTRANS), 32'h2);
    check_eq("t4_new_haddr", 32'(HADDR), 32'h44);
    tick();
    HRDATA = 32'h5555AAAA;
    tick();
    HRDATA = 32'h0;
    check_eq("t4_new_rv", 32'(rsp_valid), 32'h1);
    check_eq("t4_new_rdata", rsp_rdata, 32'h5555AAAA);
    check_eq("t4_new_err", 32'(rsp_err), 32'h0);
    tick();

    // Incrementing writes across a 1 KB boundary
    offer(1'b1, 16'h03F8, 32'hA1A1A1A1);
    tick();
    offer(1'b1, 16'h03FC, 32'hA2A2A2A2);
    check_eq("t5_htrans_0", 32'(HTRANS), 32'h2);
    check_eq("t5_haddr_0", 32'(HADDR), 32'h3F8);
    check_eq("t5_hburst_0", 32'(HBURST), 32'(c_exp_burst));
    tick();
    offer(1'b1, 16'h0400, 32'hA3A3A3A3);
    check_eq("t5_htrans_1", 32'(HTRANS), 32'(c_exp_mid));
    check_eq("t5_haddr_1", 32'(HADDR), 32'h3FC);
    check_eq("t5_hwdata_0", HWDATA, 32'hA1A1A1A1);
    tick();
    idle_cmd();
    check_eq("t5_htrans_2", 32'(HTRANS), 32'h2);
    check_eq("t5_haddr_2", 32'(HADDR), 32'h400);
    check_eq("t5_hburst_2", 32'(HBURST), 32'(c_exp_burst));
    check_eq("t5_hwdata_1", HWDATA, 32'hA2A2A2A2);
    check_eq("t5_rv_0", 32'(rsp_valid), 32'h1);
    tick();
    check_eq("t5_hwdata_2", HWDATA, 32'hA3A3A3A3);
    check_eq("t5_rv_1", 32'(rsp_valid), 32'h1);
    tick();
    check_eq("t5_rv_2", 32'(rsp_valid), 32'h1);
    tick();
    check_eq("t5_rv_end", 32'(rsp_valid), 32'h0);
    check_eq("t5_htrans_end", 32'(HTRANS), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
